// File: rtl/bcd_stream_decoder.sv
// Streaming BCD decoder: one-hot decode of every accepted digit, plus binary
// accumulation of up to DIGITS digits per number, handed off on a held valid/ready port.
module bcd_stream_decoder #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_bcd,
  input  logic             in_last,
  output logic             dig_valid,
  output logic [9:0]       dig_onehot,
  output logic             dig_err,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [BIN_W-1:0] bin_out,
  output logic [3:0]       bin_ndig,
  output logic             bin_err
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             dig_valid_q, dig_err_q;
  logic [9:0]       dig_onehot_q, onehot_d;
  logic             bin_valid_q, bin_err_q;
  logic [BIN_W-1:0] bin_out_q;
  logic [3:0]       bin_ndig_q;
  logic             accept, bad_dig, final_dig;
  logic [3:0]       dig_val;

  always_comb begin
    bad_dig   = (in_bcd > 4'd9);
    dig_val   = bad_dig ? 4'd0 : in_bcd;
    onehot_d  = bad_dig ? 10'd0 : (10'd1 << in_bcd);
    // acc*10 as shift-add; the sum wraps at BIN_W bits
    acc_d     = (acc_q << 3) + (acc_q << 1) + BIN_W'(dig_val);
    cnt_d     = cnt_q + 4'd1;
    sticky_d  = sticky_q | bad_dig;
    final_dig = in_last || (cnt_q == 4'(DIGITS - 1));
  end

  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
      dig_valid_q  <= 1'b0;
      dig_onehot_q <= '0;
      dig_err_q    <= 1'b0;
      bin_valid_q  <= 1'b0;
      bin_out_q    <= '0;
      bin_ndig_q   <= '0;
      bin_err_q    <= 1'b0;
    end else begin
      dig_valid_q <= accept;
      if (accept) begin
        dig_onehot_q <= onehot_d;
        dig_err_q    <= bad_dig;
      end
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (final_dig) begin
              // Result is published straight from the next-state value, so the
              // accumulator itself is left for the hand-off to clear.
              bin_out_q   <= acc_d;
              bin_ndig_q  <= cnt_d;
              bin_err_q   <= sticky_d;
              bin_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              acc_q    <= acc_d;
              cnt_q    <= cnt_d;
              sticky_q <= sticky_d;
            end
          end
        end
        HOLD: begin
          if (bin_ready) begin
            bin_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign dig_valid  = dig_valid_q;
  assign dig_onehot = dig_onehot_q;
  assign dig_err    = dig_err_q;
  assign bin_valid  = bin_valid_q;
  assign bin_out    = bin_out_q;
  assign bin_ndig   = bin_ndig_q;
  assign bin_err    = bin_err_q;

endmodule

// File: tb/tb_bcd_stream_decoder.sv
// Self-checking bench for bcd_stream_decoder: directed scenarios plus randomized
// numbers compared against a decimal-arithmetic reference model.
module tb_bcd_stream_decoder;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_bcd = 4'd0;
  logic             in_last = 1'b0;
  logic             dig_valid;
  logic [9:0]       dig_onehot;
  logic             dig_err;
  logic             bin_valid;
  logic             bin_ready = 1'b0;
  logic [BIN_W-1:0] bin_out;
  logic [3:0]       bin_ndig;
  logic             bin_err;

  int checks = 0;
  int errors = 0;

  logic       dv_s, de_s;
  logic [9:0] oh_s;

  always #5 clk = ~clk;

  bcd_stream_decoder #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bcd(in_bcd), .in_last(in_last), .dig_valid(dig_valid),
    .dig_onehot(dig_onehot), .dig_err(dig_err), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .bin_out(bin_out), .bin_ndig(bin_ndig), .bin_err(bin_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one digit, wait for acceptance, and capture the digit-port response.
  task automatic send(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_bcd = d; in_last = last;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
    end
    tick();
    dv_s = dig_valid; oh_s = dig_onehot; de_s = dig_err;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take();
    bin_ready = 1'b1;
    tick();
    bin_ready = 1'b0;
  endtask

  function automatic logic [9:0] ref_onehot(input int d);
    logic [9:0] r;
    r = '0;
    for (int n = 0; n < 10; n++) if (d == n) r[n] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    checks++; if ({dig_valid, dig_onehot, dig_err} !== 12'd0) begin errors++; $display("FAIL reset_dig_port: got %0h, required 0", {dig_valid, dig_onehot, dig_err}); end
    checks++; if ({bin_valid, bin_out, bin_ndig, bin_err} !== 20'd0) begin errors++; $display("FAIL reset_bin_port: got %0h, required 0", {bin_valid, bin_out, bin_ndig, bin_err}); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [9:0] exp_oh [4];
    exp_oh = '{10'h002, 10'h004, 10'h008, 10'h010};
    bin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 1), 1'b0);
      checks++; if ({dv_s, oh_s, de_s} !== {1'b1, exp_oh[i], 1'b0}) begin errors++; $display("FAIL basic_digit%0d: got dv=%0b oh=%0h err=%0b, required dv=1 oh=%0h err=0", i, dv_s, oh_s, de_s, exp_oh[i]); end
      checks++; if (bin_valid !== (i == 3)) begin errors++; $display("FAIL basic_bin_valid%0d: got %0b, required %0b", i, bin_valid, (i == 3)); end
    end
    checks++; if ({bin_out, bin_ndig, bin_err} !== {14'd1234, 4'd4, 1'b0}) begin errors++; $display("FAIL basic_result: got out=%0d ndig=%0d err=%0b, required 1234/4/0", bin_out, bin_ndig, bin_err); end
    tick();
    bin_ready = 1'b0;
    checks++; if ({bin_valid, in_ready, dig_valid} !== 3'b010) begin errors++; $display("FAIL basic_taken: got bv/ir/dv=%b, required 010", {bin_valid, in_ready, dig_valid}); end
  endtask

  task automatic test_last();
    send(4'd7, 1'b0);
    send(4'd5, 1'b1);
    checks++; if ({bin_valid, bin_out, bin_ndig, bin_err} !== {1'b1, 14'd75, 4'd2, 1'b0}) begin errors++; $display("FAIL last_result: got bv=%0b out=%0d ndig=%0d err=%0b, required 1/75/2/0", bin_valid, bin_out, bin_ndig, bin_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL last_hold_ready: got %0b, required 0", in_ready); end
    take();
    checks++; if ({bin_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL last_taken: got bv/ir=%b, required 01", {bin_valid, in_ready}); end
  endtask

  task automatic test_illegal();
    send(4'd3, 1'b0);
    send(4'hC, 1'b0);
    checks++; if ({dv_s, oh_s, de_s} !== {1'b1, 10'h000, 1'b1}) begin errors++; $display("FAIL illegal_digit: got dv=%0b oh=%0h err=%0b, required 1/0/1", dv_s, oh_s, de_s); end
    send(4'd1, 1'b1);
    checks++; if (de_s !== 1'b0) begin errors++; $display("FAIL illegal_next_err: got %0b, required 0", de_s); end
    checks++; if ({bin_out, bin_ndig, bin_err} !== {14'd301, 4'd3, 1'b1}) begin errors++; $display("FAIL illegal_result: got out=%0d ndig=%0d err=%0b, required 301/3/1", bin_out, bin_ndig, bin_err); end
    take();
    send(4'd4, 1'b1);
    checks++; if ({bin_out, bin_ndig, bin_err} !== {14'd4, 4'd1, 1'b0}) begin errors++; $display("FAIL illegal_sticky_clear: got out=%0d ndig=%0d err=%0b, required 4/1/0", bin_out, bin_ndig, bin_err); end
    take();
  endtask

  task automatic test_backpressure();
    send(4'd5, 1'b0); send(4'd6, 1'b0); send(4'd7, 1'b0); send(4'd8, 1'b0);
    checks++; if ({bin_valid, bin_out} !== {1'b1, 14'd5678}) begin errors++; $display("FAIL bp_result: got bv=%0b out=%0d, required 1/5678", bin_valid, bin_out); end
    in_valid = 1'b1; in_bcd = 4'd6; in_last = 1'b0; bin_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({in_ready, dig_valid, bin_valid, bin_out} !== {3'b001, 14'd5678}) begin errors++; $display("FAIL bp_hold%0d: got ir=%0b dv=%0b bv=%0b out=%0d, required 0/0/1/5678", i, in_ready, dig_valid, bin_valid, bin_out); end
    end
    bin_ready = 1'b1;
    tick();
    bin_ready = 1'b0;
    checks++; if ({bin_valid, in_ready, dig_valid} !== 3'b010) begin errors++; $display("FAIL bp_release: got bv/ir/dv=%b, required 010", {bin_valid, in_ready, dig_valid}); end
    tick();
    in_valid = 1'b0;
    checks++; if ({dig_valid, dig_onehot} !== {1'b1, 10'h040}) begin errors++; $display("FAIL bp_accept6: got dv=%0b oh=%0h, required 1/040", dig_valid, dig_onehot); end
    send(4'd2, 1'b1);
    checks++; if ({bin_out, bin_ndig} !== {14'd62, 4'd2}) begin errors++; $display("FAIL bp_next_number: got out=%0d ndig=%0d, required 62/2", bin_out, bin_ndig); end
    take();
  endtask

  task automatic test_reset_mid();
    send(4'd8, 1'b0);
    send(4'd8, 1'b0);
    checks++; if (dig_onehot !== 10'h100) begin errors++; $display("FAIL rstmid_pre: got oh=%0h, required 100", dig_onehot); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dig_valid, dig_onehot, dig_err, bin_valid, bin_out, bin_ndig, bin_err} !== 32'd0) begin errors++; $display("FAIL rstmid_outputs: got %0h, required 0", {dig_valid, dig_onehot, dig_err, bin_valid, bin_out, bin_ndig, bin_err}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b, required 1", in_ready); end
    #1 rst_n = 1'b1;
    send(4'd9, 1'b1);
    checks++; if ({bin_valid, bin_out, bin_ndig, bin_err} !== {1'b1, 14'd9, 4'd1, 1'b0}) begin errors++; $display("FAIL rstmid_result: got bv=%0b out=%0d ndig=%0d err=%0b, required 1/9/1/0", bin_valid, bin_out, bin_ndig, bin_err); end
    take();
  endtask

  task automatic test_max();
    for (int i = 0; i < 4; i++) send(4'd9, 1'b0);
    checks++; if ({bin_valid, bin_out, bin_ndig, bin_err} !== {1'b1, 14'h270F, 4'd4, 1'b0}) begin errors++; $display("FAIL max_result: got bv=%0b out=%0h ndig=%0d err=%0b, required 1/270F/4/0", bin_valid, bin_out, bin_ndig, bin_err); end
    take();
  endtask

  task automatic test_random();
    int         len, mval, idle, hold;
    logic       use_last, merr, fin;
    logic [3:0] d;
    for (int k = 0; k < 60; k++) begin
      len      = $urandom_range(DIGITS, 1);
      use_last = (len < DIGITS) ? 1'b1 : 1'($urandom_range(1, 0));
      mval = 0; merr = 1'b0;
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9, 0));
        idle = $urandom_range(2, 0);
        for (int j = 0; j < idle; j++) begin
          in_bcd = 4'($urandom); bin_ready = 1'($urandom);
          tick();
          checks++; if (dig_valid !== 1'b0) begin errors++; $display("FAIL rand_idle_dv: num %0d got %0b, required 0", k, dig_valid); end
        end
        bin_ready = 1'b0;
        fin = (i == len - 1);
        send(d, use_last && fin);
        mval = mval * 10 + ((d <= 9) ? int'(d) : 0);
        merr = merr | (d > 9);
        checks++; if ({dv_s, oh_s, de_s} !== {1'b1, ref_onehot(int'(d)), (d > 4'd9)}) begin errors++; $display("FAIL rand_digit: num %0d digit %0d got dv=%0b oh=%0h err=%0b, required 1/%0h/%0b", k, d, dv_s, oh_s, de_s, ref_onehot(int'(d)), (d > 4'd9)); end
        checks++; if (bin_valid !== fin) begin errors++; $display("FAIL rand_bin_valid: num %0d pos %0d got %0b, required %0b", k, i, bin_valid, fin); end
      end
      checks++; if ({bin_out, bin_ndig, bin_err} !== {BIN_W'(mval), 4'(len), merr}) begin errors++; $display("FAIL rand_result: num %0d got out=%0d ndig=%0d err=%0b, required %0d/%0d/%0b", k, bin_out, bin_ndig, bin_err, mval, len, merr); end
      hold = $urandom_range(3, 0);
      for (int j = 0; j < hold; j++) tick();
      checks++; if ({bin_valid, in_ready, bin_out} !== {2'b10, BIN_W'(mval)}) begin errors++; $display("FAIL rand_hold: num %0d got bv=%0b ir=%0b out=%0d, required 1/0/%0d", k, bin_valid, in_ready, bin_out, mval); end
      take();
      checks++; if ({bin_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rand_taken: num %0d got bv/ir=%b, required 01", k, {bin_valid, in_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_max();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_stream_decoder.md
Name: bcd_stream_decoder

Overview:
- Inverse of the team's one-hot-to-BCD encoder.
- Accepts a stream of 4-bit BCD digits over a valid/ready handshake, most significant digit first.
- Emits a registered 10-bit one-hot decode of each digit.
- Accumulates up to DIGITS digits into a binary number, presented on a held valid/ready result port.
- Sits between keypad/serial BCD sources and binary datapath logic.

Parameters:
- DIGITS, 4: maximum digits per number; legal range 1..15.
- BIN_W, 14: width of the binary result; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_bcd/in_last are valid.
- in_ready  output  1  block can accept a digit; equals (state == ACCUM).
- in_bcd  input  4  BCD digit; codes 10..15 are illegal.
- in_last  input  1  accepted digit is the final digit of the number.
- dig_valid  output  1  one-cycle pulse; dig_onehot/dig_err are valid.
- dig_onehot  output  10  one-hot decode: bit n set iff the digit equals n; all zero for illegal codes.
- dig_err  output  1  pulses with dig_valid when the digit was illegal.
- bin_valid  output  1  result available; held until it is taken.
- bin_ready  input  1  consumer takes the result.
- bin_out  output  BIN_W  binary value of the number.
- bin_ndig  output  4  number of digits accumulated, 1..DIGITS.
- bin_err  output  1  at least one illegal digit occurred in this number.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to ACCUM; accumulator, digit count and error flag go to 0.
  - All outputs go to 0 except in_ready, which reads 1 once the state is ACCUM.
- Accept: a digit is accepted when in_valid && in_ready at a rising clk edge.
- Digit decode (1 cycle latency):
  - The cycle after acceptance: dig_valid = 1, dig_onehot = 1 << d for d <= 9, else 0 with dig_err = 1.
  - dig_valid is deasserted in all other cycles; dig_onehot/dig_err hold their last value.
  - There is no backpressure on the digit port.
- Arithmetic:
  - acc_next = acc*10 + d', where d' = d if d <= 9, else 0.
  - acc*10 is implemented as (acc<<3)+(acc<<1), truncated to BIN_W bits.
  - A sticky error flag ORs in (d > 9).
- FSM, two states:
  - ACCUM:
    - in_ready = 1.
    - On accept with in_last = 1, or on the DIGITS-th digit: register bin_out = acc_next, bin_ndig = count+1, bin_err = sticky | (d > 9); set bin_valid = 1; go to HOLD. bin_valid rises the cycle after the final accept, the same cycle as that digit's dig_valid.
    - On any other accept: acc = acc_next, count++, stay in ACCUM.
  - HOLD:
    - in_ready = 0.
    - bin_out, bin_ndig and bin_err are stable.
    - When bin_valid && bin_ready: bin_valid <= 0, acc/count/sticky <= 0, go to ACCUM. in_ready is 1 in the following cycle.
- Boundaries:
  - in_last on the DIGITS-th digit is a single termination, not a double one.
  - in_last asserted on the first digit gives bin_ndig = 1.
  - bin_ready asserted while in ACCUM is ignored.
  - in_valid asserted while in HOLD is not accepted; the source must hold its digit.
  - Reset mid-number or mid-HOLD discards the partial or pending result without emitting it.
  - in_valid may toggle freely; idle cycles do not affect the accumulator.

Test Plan:
- Digits 1,2,3,4, no in_last, bin_ready = 1:
  - dig_onehot sequence 0x002, 0x004, 0x008, 0x010.
  - bin_out = 1234 (0x4D2), bin_ndig = 4, bin_err = 0.
  - bin_valid rises one cycle after the 4th accept.
- Digit 7, then 5 with in_last: bin_out = 75, bin_ndig = 2; in_ready returns to 1 the cycle after the result is taken.
- Digits 3, 0xC, 1 with in_last:
  - Second dig_valid carries dig_onehot = 0 and dig_err = 1.
  - bin_out = 301, bin_err = 1, bin_ndig = 3.
- Backpressure: after a complete 4-digit number, hold bin_ready = 0 for 5 cycles with in_valid = 1 and in_bcd = 6:
  - in_ready = 0 and bin_out stable throughout; no dig_valid pulses.
  - Raise bin_ready: bin_valid drops; the 6 is accepted exactly one cycle later.
- Reset mid-number: accept 8, 8; pulse rst_n low asynchronously between edges:
  - All outputs 0 immediately.
  - Then 9 with in_last gives bin_out = 9, bin_ndig = 1.
- Maximum value: 9,9,9,9 gives bin_out = 9999 (14'h270F), bin_err = 0.
